// File: rtl/memory_sdp_be.sv
// -----------------------------------------------------------------------------
// memory_sdp_be
// Simple dual-port synchronous RAM. It has one write port and one read port on
// a single clock, with per-byte write enables and a read latency of 1 or 2
// that is signalled by an rvalid strobe. The same-address read/write policy is
// selectable. An optional zero-fill sweep runs after reset, so datapath blocks
// see deterministic table contents.
//
// Ports
//   clk        rising-edge clock for all logic
//   rst        synchronous reset, active-high
//   init_done  high once the array is ready; port operations accepted only then
//   wren       write request
//   waddr      write address
//   wbe        byte-lane write enables (bit i covers wdata[i*ByteWidth +: ByteWidth])
//   wdata      write data
//   rden       read request
//   raddr      read address
//   rdata      read data, valid while rvalid=1, held otherwise
//   rvalid     one-cycle strobe per accepted read
// -----------------------------------------------------------------------------
module memory_sdp_be #(
  parameter int AddrWidth    = 8,
  parameter int DataWidth    = 64,
  parameter int ByteWidth    = 8,
  parameter int ReadLatency  = 1,
  parameter int WriteFirst   = 0,
  parameter int ClearOnReset = 1,
  localparam int NumBytes    = DataWidth / ByteWidth
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 init_done,
  input  logic                 wren,
  input  logic [AddrWidth-1:0] waddr,
  input  logic [NumBytes-1:0]  wbe,
  input  logic [DataWidth-1:0] wdata,
  input  logic                 rden,
  input  logic [AddrWidth-1:0] raddr,
  output logic [DataWidth-1:0] rdata,
  output logic                 rvalid
);

  localparam int Depth = 2 ** AddrWidth;
  localparam logic [AddrWidth-1:0] CntLast = '1;

  if (!(ReadLatency == 1 || ReadLatency == 2)) begin : g_bad_latency
    $error("memory_sdp_be: ReadLatency must be 1 or 2");
  end
  if ((DataWidth % ByteWidth) != 0) begin : g_bad_width
    $error("memory_sdp_be: DataWidth must be a multiple of ByteWidth");
  end

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  localparam state_e StAfterReset = (ClearOnReset != 0) ? ST_CLEAR : ST_READY;

  // Lanes of wd selected by be replace the matching lanes of old.
  function automatic logic [DataWidth-1:0] lane_merge(
    input logic [DataWidth-1:0] old,
    input logic [DataWidth-1:0] wd,
    input logic [NumBytes-1:0]  be
  );
    logic [DataWidth-1:0] res;
    res = old;
    for (int i = 0; i < NumBytes; i++) begin
      if (be[i]) res[i*ByteWidth +: ByteWidth] = wd[i*ByteWidth +: ByteWidth];
    end
    return res;
  endfunction

  logic [DataWidth-1:0] mem_q [Depth];

  state_e               state_q, state_d;
  logic [AddrWidth-1:0] cnt_q, cnt_d;
  logic                 init_done_q, init_done_d;
  logic                 clr_we;
  logic                 wr_acc, rd_acc;
  logic [DataWidth-1:0] rd_old, rd_word;
  logic [DataWidth-1:0] rdata_q;
  logic                 rvalid_q;

  // Port operations are only honoured once the array is declared ready.
  assign wr_acc = init_done_q & wren & ~rst;
  assign rd_acc = init_done_q & rden & ~rst;

  // ---------------------------------------------------------------------------
  // Control: zero-fill sweep and ready flag
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StAfterReset;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= init_done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_done_d = init_done_q;
    clr_we      = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        clr_we = ~rst;
        cnt_d  = cnt_q + AddrWidth'(1);
        // The edge that zeroes the last word also opens the ports.
        if (cnt_q == CntLast) begin
          state_d     = ST_READY;
          init_done_d = 1'b1;
        end
      end
      ST_READY: begin
        init_done_d = 1'b1;
      end
      default: begin
        state_d = ST_READY;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Array write: sweep has priority; ports are closed while it runs anyway
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem_q[cnt_q] <= '0;
    end else if (wr_acc) begin
      for (int i = 0; i < NumBytes; i++) begin
        if (wbe[i]) mem_q[waddr][i*ByteWidth +: ByteWidth] <= wdata[i*ByteWidth +: ByteWidth];
      end
    end
  end

  // Collision bypass: with write-first, the same-edge write lanes are folded
  // into the returned word; otherwise the pre-write word is returned.
  always_comb begin
    rd_old  = mem_q[raddr];
    rd_word = rd_old;
    if ((WriteFirst != 0) && wr_acc && (waddr == raddr)) begin
      rd_word = lane_merge(rd_old, wdata, wbe);
    end
  end

  // ---------------------------------------------------------------------------
  // Read pipeline
  // ---------------------------------------------------------------------------
  if (ReadLatency == 1) begin : g_lat1
    always_ff @(posedge clk) begin
      if (rst) begin
        rvalid_q <= 1'b0;
        rdata_q  <= '0;
      end else begin
        rvalid_q <= rd_acc;
        if (rd_acc) rdata_q <= rd_word;
      end
    end
  end else begin : g_lat2
    logic                 rd_vld_p0;
    logic [DataWidth-1:0] rd_data_p0;

    // --- stage p0: array word captured on the accepting edge ---
    always_ff @(posedge clk) begin
      if (rst) rd_vld_p0 <= 1'b0;
      else     rd_vld_p0 <= rd_acc;
    end

    always_ff @(posedge clk) begin
      if (rd_acc) rd_data_p0 <= rd_word;
    end

    // --- output stage: only a valid p0 entry may replace rdata ---
    always_ff @(posedge clk) begin
      if (rst) begin
        rvalid_q <= 1'b0;
        rdata_q  <= '0;
      end else begin
        rvalid_q <= rd_vld_p0;
        if (rd_vld_p0) rdata_q <= rd_data_p0;
      end
    end
  end

  assign init_done = init_done_q;
  assign rdata     = rdata_q;
  assign rvalid    = rvalid_q;

endmodule

// File: tb/tb_memory_sdp_be.sv
module tb_memory_sdp_be;

  localparam int AW    = 4;
  localparam int DW    = 64;
  localparam int NB    = 8;
  localparam int DEPTH = 16;
  localparam int NI    = 4;

  // Instance configurations: read latency, write-first, clear-on-reset.
  localparam int LAT  [NI] = '{1, 1, 2, 2};
  localparam int WFP  [NI] = '{0, 1, 0, 1};
  localparam int CORP [NI] = '{1, 1, 1, 0};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          wren, rden;
  logic [AW-1:0] waddr, raddr;
  logic [NB-1:0] wbe;
  logic [DW-1:0] wdata;

  logic          id_w [NI];
  logic          rv_w [NI];
  logic [DW-1:0] rd_w [NI];

  memory_sdp_be #(.AddrWidth(AW), .DataWidth(DW), .ByteWidth(8), .ReadLatency(1),
                  .WriteFirst(0), .ClearOnReset(1)) u_dut0 (
    .clk(clk), .rst(rst), .init_done(id_w[0]), .wren(wren), .waddr(waddr), .wbe(wbe),
    .wdata(wdata), .rden(rden), .raddr(raddr), .rdata(rd_w[0]), .rvalid(rv_w[0]));
  memory_sdp_be #(.AddrWidth(AW), .DataWidth(DW), .ByteWidth(8), .ReadLatency(1),
                  .WriteFirst(1), .ClearOnReset(1)) u_dut1 (
    .clk(clk), .rst(rst), .init_done(id_w[1]), .wren(wren), .waddr(waddr), .wbe(wbe),
    .wdata(wdata), .rden(rden), .raddr(raddr), .rdata(rd_w[1]), .rvalid(rv_w[1]));
  memory_sdp_be #(.AddrWidth(AW), .DataWidth(DW), .ByteWidth(8), .ReadLatency(2),
                  .WriteFirst(0), .ClearOnReset(1)) u_dut2 (
    .clk(clk), .rst(rst), .init_done(id_w[2]), .wren(wren), .waddr(waddr), .wbe(wbe),
    .wdata(wdata), .rden(rden), .raddr(raddr), .rdata(rd_w[2]), .rvalid(rv_w[2]));
  memory_sdp_be #(.AddrWidth(AW), .DataWidth(DW), .ByteWidth(8), .ReadLatency(2),
                  .WriteFirst(1), .ClearOnReset(0)) u_dut3 (
    .clk(clk), .rst(rst), .init_done(id_w[3]), .wren(wren), .waddr(waddr), .wbe(wbe),
    .wdata(wdata), .rden(rden), .raddr(raddr), .rdata(rd_w[3]), .rvalid(rv_w[3]));

  int checks   = 0;
  int failures = 0;

  // Reference model: word array with a known-flag per word, edge counter for
  // the sweep, and a one-deep holding slot for the two-edge read.
  logic [DW-1:0] mmem   [NI][DEPTH];
  bit            mknown [NI][DEPTH];
  int            mcnt   [NI];
  bit            mdone  [NI];
  bit            mrv    [NI];
  logic [DW-1:0] mrd    [NI];
  bit            mrk    [NI];
  bit            pv     [NI];
  logic [DW-1:0] pd     [NI];
  bit            pk     [NI];

  typedef struct {
    bit            wr;
    logic [AW-1:0] wa;
    logic [NB-1:0] be;
    logic [DW-1:0] wd;
    bit            rd;
    logic [AW-1:0] ra;
    logic [DW-1:0] e0;  // expected read word, read-first instances
    logic [DW-1:0] e1;  // expected read word, write-first instances
  } vec_t;
  vec_t tbl [12];

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] o, input logic [DW-1:0] d,
                                          input logic [NB-1:0] be);
    logic [DW-1:0] r;
    r = o;
    for (int b = 0; b < NB; b++) if (be[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic model_step();
    bit            acc, wacc, k;
    logic [DW-1:0] w;
    for (int i = 0; i < NI; i++) begin
      if (rst) begin
        mrd[i] = '0; mrk[i] = 1'b1; mrv[i] = 1'b0; pv[i] = 1'b0;
        mcnt[i] = 0; mdone[i] = 1'b0;
      end else begin
        acc  = mdone[i] && rden;
        wacc = mdone[i] && wren;
        w    = mmem[i][raddr];
        k    = mknown[i][raddr];
        if (acc && WFP[i] != 0 && wacc && waddr == raddr) begin
          w = merge(w, wdata, wbe);
          k = k || (wbe == 8'hFF);
        end
        if (LAT[i] == 1) begin
          mrv[i] = acc;
          if (acc) begin mrd[i] = w; mrk[i] = k; end
        end else begin
          mrv[i] = pv[i];
          if (pv[i]) begin mrd[i] = pd[i]; mrk[i] = pk[i]; end
          pv[i] = acc; pd[i] = w; pk[i] = k;
        end
        if (wacc) begin
          mmem[i][waddr] = merge(mmem[i][waddr], wdata, wbe);
          if (wbe == 8'hFF) mknown[i][waddr] = 1'b1;
        end
        if (!mdone[i]) begin
          if (CORP[i] != 0) begin
            mmem[i][mcnt[i]]   = '0;
            mknown[i][mcnt[i]] = 1'b1;
            mcnt[i]++;
            if (mcnt[i] == DEPTH) mdone[i] = 1'b1;
          end else begin
            mdone[i] = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("init_done_%0d", i), DW'(id_w[i]), DW'(mdone[i]));
      chk($sformatf("rvalid_%0d", i), DW'(rv_w[i]), DW'(mrv[i]));
      if (mrk[i]) chk($sformatf("rdata_%0d", i), rd_w[i], mrd[i]);
    end
  endtask

  // One clock: model follows the edge, DUT outputs sampled 1 time unit later.
  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic drive(input bit we, input logic [AW-1:0] wa, input logic [NB-1:0] be,
                       input logic [DW-1:0] wd, input bit re, input logic [AW-1:0] ra);
    wren = we; waddr = wa; wbe = be; wdata = wd; rden = re; raddr = ra;
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, '0, 1'b0, '0);
  endtask

  initial begin
    int n0, n3;
    int nrv [NI];

    tbl[0]  = '{1'b1, 4'd5, 8'hFF, 64'h1122334455667788, 1'b0, 4'd0, 64'h0, 64'h0};
    tbl[1]  = '{1'b1, 4'd5, 8'h0F, 64'hAAAAAAAAAAAAAAAA, 1'b0, 4'd0, 64'h0, 64'h0};
    tbl[2]  = '{1'b0, 4'd0, 8'h00, 64'h0, 1'b1, 4'd5, 64'h11223344AAAAAAAA, 64'h11223344AAAAAAAA};
    tbl[3]  = '{1'b1, 4'd7, 8'hFF, 64'h0, 1'b0, 4'd0, 64'h0, 64'h0};
    tbl[4]  = '{1'b1, 4'd7, 8'h01, 64'hFFFFFFFFFFFFFFFF, 1'b1, 4'd7, 64'h0, 64'hFF};
    tbl[5]  = '{1'b0, 4'd0, 8'h00, 64'h0, 1'b1, 4'd7, 64'hFF, 64'hFF};
    tbl[6]  = '{1'b1, 4'd3, 8'hFF, 64'hDEAD, 1'b0, 4'd0, 64'h0, 64'h0};
    tbl[7]  = '{1'b0, 4'd0, 8'h00, 64'h0, 1'b1, 4'd3, 64'hDEAD, 64'hDEAD};
    tbl[8]  = '{1'b1, 4'd3, 8'h00, 64'hFFFFFFFFFFFFFFFF, 1'b1, 4'd3, 64'hDEAD, 64'hDEAD};
    tbl[9]  = '{1'b0, 4'd0, 8'h00, 64'h0, 1'b1, 4'd3, 64'hDEAD, 64'hDEAD};
    tbl[10] = '{1'b1, 4'd3, 8'h80, 64'h5500000000000000, 1'b1, 4'd3,
                64'hDEAD, 64'h550000000000DEAD};
    tbl[11] = '{1'b0, 4'd0, 8'h00, 64'h0, 1'b1, 4'd3, 64'h550000000000DEAD, 64'h550000000000DEAD};

    // Reset held three cycles, then time the ready flag.
    rst = 1'b1;
    idle();
    repeat (3) cyc();
    rst = 1'b0;
    n0 = -1; n3 = -1;
    for (int k = 1; k <= 40 && n0 < 0; k++) begin
      cyc();
      if (n3 < 0 && id_w[3]) n3 = k;
      if (id_w[0]) n0 = k;
    end
    chk("init_latency_clear", DW'(n0), DW'(16));
    chk("init_latency_noclear", DW'(n3), DW'(1));

    // Back-to-back reads of the whole cleared array.
    for (int i = 0; i < NI; i++) nrv[i] = 0;
    for (int a = 0; a < DEPTH; a++) begin
      drive(1'b0, '0, '0, '0, 1'b1, AW'(a));
      cyc();
      for (int i = 0; i < NI; i++) nrv[i] += int'(rv_w[i]);
    end
    idle();
    repeat (3) begin
      cyc();
      for (int i = 0; i < NI; i++) nrv[i] += int'(rv_w[i]);
    end
    for (int i = 0; i < NI; i++) chk($sformatf("b2b_rvalid_count_%0d", i), DW'(nrv[i]), DW'(16));

    // Directed vectors: byte lanes, collisions, no-op writes.
    for (int r = 0; r < 12; r++) begin
      drive(tbl[r].wr, tbl[r].wa, tbl[r].be, tbl[r].wd, tbl[r].rd, tbl[r].ra);
      cyc();
      idle();
      cyc();
      cyc();
      if (tbl[r].rd) begin
        for (int i = 0; i < NI; i++)
          chk($sformatf("vec%0d_rdata_%0d", r, i), rd_w[i], (WFP[i] != 0) ? tbl[r].e1 : tbl[r].e0);
      end
    end

    // Preserved contents across reset without clear, and in-flight read flush.
    drive(1'b1, 4'd2, 8'hFF, 64'h55, 1'b0, '0);
    cyc();
    drive(1'b0, '0, '0, '0, 1'b1, 4'd2);
    cyc();
    idle();
    rst = 1'b1;
    cyc();
    chk("flush_rvalid_lat2_rf", DW'(rv_w[2]), DW'(0));
    chk("flush_rvalid_lat2_wf", DW'(rv_w[3]), DW'(0));
    rst = 1'b0;
    cyc();
    chk("flush_rvalid_after", DW'(rv_w[3]), DW'(0));
    chk("noclear_ready_first_edge", DW'(id_w[3]), DW'(1));
    drive(1'b0, '0, '0, '0, 1'b1, 4'd2);
    cyc();
    idle();
    cyc();
    cyc();
    chk("noclear_preserved", rd_w[3], 64'h55);
    repeat (20) cyc();

    // Reset in mid-sweep restarts it; port pulses during the sweep are ignored.
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    repeat (9) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    n0 = -1;
    for (int k = 1; k <= 40 && n0 < 0; k++) begin
      if (k >= 6 && k <= 9) drive(1'b1, 4'd1, 8'hFF, 64'hFFFFFFFFFFFFFFFF, 1'b1, 4'd0);
      else idle();
      cyc();
      if (id_w[0]) n0 = k;
    end
    chk("restart_init_latency", DW'(n0), DW'(16));
    idle();
    drive(1'b0, '0, '0, '0, 1'b1, 4'd1);
    cyc();
    idle();
    cyc();
    cyc();
    chk("sweep_write_ignored", rd_w[0], 64'h0);

    // Randomized traffic against the model.
    repeat (1500) begin
      wren  = ($urandom_range(0, 1) == 1);
      rden  = ($urandom_range(0, 1) == 1);
      waddr = AW'($urandom());
      raddr = ($urandom_range(0, 3) == 0) ? waddr : AW'($urandom());
      wbe   = ($urandom_range(0, 2) == 0) ? 8'hFF : NB'($urandom());
      wdata = {$urandom(), $urandom()};
      cyc();
    end
    idle();
    repeat (3) cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/memory_sdp_be.md
Name: memory_sdp_be

Overview:
Next-generation simple dual-port synchronous RAM: one write port, one read port, one clock. Adds per-byte write enables, a configurable read latency of 1 or 2 with a read-valid strobe, and a selectable read-during-write policy. An optional post-reset clear engine zeroes the whole array. Used as the generic buffer and table store behind datapath blocks that need deterministic contents after reset.

Parameters:
AddrWidth, 8, address bits; depth = 2**AddrWidth
DataWidth, 64, word width in bits; must be a multiple of ByteWidth
ByteWidth, 8, bits per write-enable lane; NumBytes = DataWidth/ByteWidth
ReadLatency, 1, clock edges from accepted read to rdata/rvalid; legal values 1 or 2
WriteFirst, 0, same-address read/write collision policy: 0 returns old data, 1 returns new data
ClearOnReset, 1, 1 runs the zero-fill engine after reset; 0 leaves contents untouched

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous reset, active-high
init_done  out  1  high when the array is ready and port operations are accepted
wren  in  1  write request
waddr  in  AddrWidth  write address
wbe  in  NumBytes  byte-lane write enables; bit i covers wdata[i*ByteWidth +: ByteWidth]
wdata  in  DataWidth  write data
rden  in  1  read request
raddr  in  AddrWidth  read address
rdata  out  DataWidth  read data; valid when rvalid=1
rvalid  out  1  one-cycle strobe per accepted read

Behaviour:
- Reset, on any edge with rst=1: rdata=0, rvalid=0, read pipeline valids cleared, clear counter=0, init_done=0. State goes to CLEAR if ClearOnReset=1, else READY.
- With ClearOnReset=0, init_done=1 on the first edge with rst=0. Array contents are not changed by reset and are unspecified after power-up.
- CLEAR state: on each edge with rst=0, write mem[cnt]=0 and increment cnt. The edge that writes address 2**AddrWidth-1 also sets init_done=1 and moves to READY. init_done is therefore visible after exactly 2**AddrWidth edges with rst low.
- Reset during CLEAR restarts the sweep from address 0.
- While init_done=0, wren and rden are ignored: no array update, no rvalid.
- Write, in READY with wren=1: for each i with wbe[i]=1, lane i of mem[waddr] takes lane i of wdata. Other lanes keep their value. wren=1 with wbe=0 is a no-op.
- Read, in READY with rden=1 at edge t:
  - rvalid=1 and rdata=word for exactly one cycle after edge t+ReadLatency-1. That is, after edge t for latency 1 and after edge t+1 for latency 2.
  - Throughput is one read per cycle; back-to-back reads give back-to-back rvalid.
- rdata holds its last value whenever rvalid=0 and is never overwritten by a non-valid pipeline stage.
- Collision, when wren=1 and rden=1 with waddr==raddr on the same edge:
  - WriteFirst=0: returns the pre-write word.
  - WriteFirst=1: returns the merged word, with wdata lanes where wbe=1 and old lanes elsewhere.
  - Both policies apply at either latency.
- A write to address A at edge t is visible to any read of A issued at edge t+1 or later.
- With ReadLatency=2, reset flushes the in-flight read: no rvalid after rst.
- Illegal parameter values are caught by an elaboration-time assertion: ReadLatency outside {1,2}, or DataWidth not a multiple of ByteWidth.

Test Plan:
1. Defaults, AddrWidth=4: hold rst 3 cycles, release -> init_done=0 for 16 edges, 1 after the 16th. Read addresses 0..15 back-to-back -> 16 consecutive rvalid, all rdata=0.
2. Write 0x1122334455667788 to addr 5 with wbe=0xFF, then write 0xAAAA… with wbe=0x0F to addr 5, then read addr 5 -> rdata=0x11223344AAAAAAAA.
3. ReadLatency=2: rden at edge t for addr 3 (content 0xDEAD) -> rvalid high only after edge t+1 with rdata=0xDEAD. rdata unchanged in the surrounding cycles.
4. Collision at addr 7 (old 0x0, write 0xFFFF…, wbe=0x01) -> WriteFirst=0 returns 0x0; WriteFirst=1 returns 0x00000000000000FF. Next read of addr 7 returns 0xFF in both configurations.
5. Assert rst at clear count 9, release -> sweep restarts, init_done after a further full 2**AddrWidth edges. wren/rden pulses during the sweep produce no rvalid and no data change.
6. ClearOnReset=0: preload addr 2=0x55, pulse rst -> init_done=1 on the first edge after release, addr 2 still reads 0x55. A ReadLatency=2 read in flight at rst produces no rvalid.
